// File: rtl/vga_scan_timer.sv
// vga_scan_timer: raster timing generator (x/y, sync, blank, vblank interrupt)
module vga_scan_timer #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP = 29,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        interrupt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC;
  localparam logic [10:0] X_MAX = 11'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX = 10'(V_TOTAL - 1);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW != 0;
  logic [10:0] nx;
  logic [9:0] ny;
  logic [31:0] nx_w, ny_w;
  logic h_act, v_act, set_irq;
  // next-state counters; sync/blank/irq decode from these so they line up with the registered x/y
  always_comb begin
    nx = (x == X_MAX) ? 11'd0 : x + 11'd1;
    ny = (x != X_MAX) ? y : (y == Y_MAX) ? 10'd0 : y + 10'd1;
    nx_w = {21'd0, nx};
    ny_w = {22'd0, ny};
    h_act = (nx_w >= 32'(HS_START)) && (nx_w < 32'(HS_END));
    v_act = (ny_w >= 32'(VS_START)) && (ny_w < 32'(VS_END));
    set_irq = (nx == 11'd0) && (ny_w == 32'(V_ACTIVE));
  end
  // output registers; set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
      blank <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      x <= nx;
      y <= ny;
      hsync <= h_act ^ SYNC_IDLE;
      vsync <= v_act ^ SYNC_IDLE;
      blank <= (nx_w >= 32'(H_ACTIVE)) || (ny_w >= 32'(V_ACTIVE));
      interrupt <= set_irq || (interrupt && !cli);
    end
  end
endmodule

// File: tb/tb_vga_scan_timer.sv
// tb_vga_scan_timer: directed checks on a default XGA instance and a shrunken-timing instance
module tb_vga_scan_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cli = 1'b0;
  logic [10:0] dx, sx;
  logic [9:0] dy, sy;
  logic dhs, dvs, dbl, dirq, shs, svs, sbl, sirq;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_scan_timer u_def (
    .clk(clk), .rst_n(rst_n), .cli(1'b0),
    .x(dx), .y(dy), .hsync(dhs), .vsync(dvs), .blank(dbl), .interrupt(dirq)
  );

  // H_TOTAL=25 (hsync x 18..21), V_TOTAL=13 (vsync y 9..10), frame = 325 clocks
  vga_scan_timer #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE_LOW(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .cli(cli),
    .x(sx), .y(sy), .hsync(shs), .vsync(svs), .blank(sbl), .interrupt(sirq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_x"}, 32'(sx), 0);
    check({tag, "_y"}, 32'(sy), 0);
    check({tag, "_hs"}, 32'(shs), 1);
    check({tag, "_vs"}, 32'(svs), 1);
    check({tag, "_bl"}, 32'(sbl), 0);
    check({tag, "_irq"}, 32'(sirq), 0);
  endtask

  initial begin
    tick(3);
    check_small_reset("rst");
    check("rst_dx", 32'(dx), 0);
    check("rst_dhs", 32'(dhs), 1);
    check("rst_dvs", 32'(dvs), 1);
    check("rst_dbl", 32'(dbl), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1024);
    check("d1024_x", 32'(dx), 1024);
    check("d1024_bl", 32'(dbl), 1);
    check("d1024_hs", 32'(dhs), 1);
    tick(23);
    check("d1047_hs", 32'(dhs), 1);
    tick(1);
    check("d1048_x", 32'(dx), 1048);
    check("d1048_hs", 32'(dhs), 0);
    tick(135);
    check("d1183_hs", 32'(dhs), 0);
    tick(1);
    check("d1184_hs", 32'(dhs), 1);
    tick(159);
    check("d1343_x", 32'(dx), 1343);
    check("d1343_y", 32'(dy), 0);
    tick(1);
    check("dwrap_x", 32'(dx), 0);
    check("dwrap_y", 32'(dy), 1);
    check("dwrap_bl", 32'(dbl), 0);
    rst_n = 1'b0;
    #1;
    check("d_arst_x", 32'(dx), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(199);
    check("s199_x", 32'(sx), 24);
    check("s199_y", 32'(sy), 7);
    check("s199_irq", 32'(sirq), 0);
    tick(1);
    check("sset_x", 32'(sx), 0);
    check("sset_y", 32'(sy), 8);
    check("sset_bl", 32'(sbl), 1);
    check("sset_irq", 32'(sirq), 1);
    check("sset_vs", 32'(svs), 1);
    tick(25);
    check("svs9_y", 32'(sy), 9);
    check("svs9_vs", 32'(svs), 0);
    tick(24);
    check("svs9e_vs", 32'(svs), 0);
    tick(1);
    check("svs10_vs", 32'(svs), 0);
    tick(25);
    check("svs11_y", 32'(sy), 11);
    check("svs11_vs", 32'(svs), 1);
    cli = 1'b1;
    tick(1);
    cli = 1'b0;
    check("sclr_irq", 32'(sirq), 0);
    cli = 1'b1;
    tick(1);
    cli = 1'b0;
    check("sclr0_irq", 32'(sirq), 0);
    tick(48);
    check("sfw_x", 32'(sx), 0);
    check("sfw_y", 32'(sy), 0);
    check("sfw_bl", 32'(sbl), 0);
    check("sfw_vs", 32'(svs), 1);
    tick(199);
    check("s2pre_irq", 32'(sirq), 0);
    cli = 1'b1;
    tick(1);
    cli = 1'b0;
    check("sboth_y", 32'(sy), 8);
    check("sboth_irq", 32'(sirq), 1);
    tick(1);
    check("sboth1_irq", 32'(sirq), 1);
    tick(124);
    check("sstk_x", 32'(sx), 0);
    check("sstk_y", 32'(sy), 0);
    check("sstk_irq", 32'(sirq), 1);
    tick(80);
    check("smid_x", 32'(sx), 5);
    check("smid_y", 32'(sy), 3);
    #2 rst_n = 1'b0;
    #1;
    check_small_reset("sarst");
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check("srel_x", 32'(sx), 1);
    check("srel_y", 32'(sy), 0);
    tick(24);
    check("srel25_x", 32'(sx), 0);
    check("srel25_y", 32'(sy), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
